// File: rtl/exec_unit_pkg.sv
// Shared types for the exec issue path.
//   exec_op_e        : decoded operation selector for the exec unit
//   exec_unit_params : exec_op plus the two operand-select fields, carried
//                      alongside the operands through the issue slot
package exec_unit_pkg;

    typedef enum logic [3:0] {
        EXEC_ADD = 4'd0,
        EXEC_SUB = 4'd1,
        EXEC_AND = 4'd2,
        EXEC_OR  = 4'd3,
        EXEC_XOR = 4'd4,
        EXEC_SLL = 4'd5,
        EXEC_SRL = 4'd6,
        EXEC_SLT = 4'd7
    } exec_op_e;

    typedef struct packed {
        exec_op_e   exec_op;
        logic [1:0] op1_sel;
        logic [1:0] op2_sel;
    } exec_unit_params;

endpackage

// File: rtl/exec_issue_arbiter.sv
// Two-requester arbiter feeding a single-entry registered issue slot.
//
// Parameters
//   PRIO_MODE    : 0 = round-robin, 1 = fixed priority to requester 0 with a
//                  starvation guard for requester 1
//   STARVE_LIMIT : consecutive lost cycles after which requester 1 wins (1..15)
//
// Ports
//   clk, reset_n              : clock, asynchronous active-low reset
//   req_valid[1:0]            : requester i presents an operation
//   req_ready[1:0]            : requester i is accepted this cycle (combinational)
//   req{0,1}_params/op1/op2   : per-requester payload
//   issue_valid / issue_ready : output slot handshake
//   issue_params/op1/op2      : registered payload of the slot owner
//   issue_src                 : index of the requester that owns the slot
module exec_issue_arbiter
    import exec_unit_pkg::*;
#(
    parameter int PRIO_MODE    = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  exec_unit_params req0_params,
    input  exec_unit_params req1_params,
    input  logic [31:0]     req0_op1,
    input  logic [31:0]     req0_op2,
    input  logic [31:0]     req1_op1,
    input  logic [31:0]     req1_op2,
    output logic            issue_valid,
    input  logic            issue_ready,
    output exec_unit_params issue_params,
    output logic [31:0]     issue_op1,
    output logic [31:0]     issue_op2,
    output logic            issue_src
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic            issue_valid_q, issue_valid_d;
    logic            issue_src_q, issue_src_d;
    exec_unit_params issue_params_q, issue_params_d;
    logic [31:0]     issue_op1_q, issue_op1_d;
    logic [31:0]     issue_op2_q, issue_op2_d;
    logic            last_grant_q, last_grant_d;
    logic [3:0]      starve_cnt_q, starve_cnt_d;
    // Low for the first edge after reset release so a release that lands on
    // an edge can never produce a grant.
    logic            armed_q, armed_d;

    logic       slot_free;
    logic       sel;
    logic [1:0] grant;

    // Grant selection: only reads handshake bits and arbiter state, never the
    // payload, so req_ready has no path from params or operands.
    always_comb begin
        slot_free = !issue_valid_q || issue_ready;
        sel       = req_valid[1];
        if (&req_valid) begin
            if (PRIO_MODE == 0) begin
                sel = ~last_grant_q;
            end else begin
                sel = (starve_cnt_q == STARVE_MAX);
            end
        end
        grant = 2'b00;
        if (armed_q && slot_free && (|req_valid)) begin
            grant = sel ? 2'b10 : 2'b01;
        end
    end

    assign req_ready = grant;

    always_comb begin
        issue_valid_d  = issue_valid_q;
        issue_src_d    = issue_src_q;
        issue_params_d = issue_params_q;
        issue_op1_d    = issue_op1_q;
        issue_op2_d    = issue_op2_q;
        last_grant_d   = last_grant_q;
        starve_cnt_d   = starve_cnt_q;
        armed_d        = 1'b1;

        if (|grant) begin
            issue_valid_d  = 1'b1;
            issue_src_d    = sel;
            issue_params_d = sel ? req1_params : req0_params;
            issue_op1_d    = sel ? req1_op1 : req0_op1;
            issue_op2_d    = sel ? req1_op2 : req0_op2;
        end else if (issue_valid_q && issue_ready) begin
            // Data fields are left as they were; only the valid flag drops.
            issue_valid_d = 1'b0;
        end

        // Arbiter history only moves when the slot can accept.
        if (slot_free) begin
            if (PRIO_MODE == 0) begin
                if (|grant) begin
                    last_grant_d = sel;
                end
            end else begin
                if (req_valid[1] && grant[0]) begin
                    if (starve_cnt_q != STARVE_MAX) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else begin
                    starve_cnt_d = 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_valid_q  <= 1'b0;
            issue_src_q    <= 1'b0;
            issue_params_q <= '0;
            issue_op1_q    <= 32'd0;
            issue_op2_q    <= 32'd0;
            last_grant_q   <= 1'b1;     // requester 0 wins the first tie
            starve_cnt_q   <= 4'd0;
            armed_q        <= 1'b0;
        end else begin
            issue_valid_q  <= issue_valid_d;
            issue_src_q    <= issue_src_d;
            issue_params_q <= issue_params_d;
            issue_op1_q    <= issue_op1_d;
            issue_op2_q    <= issue_op2_d;
            last_grant_q   <= last_grant_d;
            starve_cnt_q   <= starve_cnt_d;
            armed_q        <= armed_d;
        end
    end

    assign issue_valid  = issue_valid_q;
    assign issue_src    = issue_src_q;
    assign issue_params = issue_params_q;
    assign issue_op1    = issue_op1_q;
    assign issue_op2    = issue_op2_q;

endmodule
